// File: rtl/tdm_demux_rx.sv
// rtl/tdm_demux_rx.sv - TDM serial link receiver: frame_sync alignment, slot deserialisation, flywheel lock
module tdm_demux_rx #(
   parameter int N_CH = 4,
   parameter int W    = 8
) (
   input  logic              clock,
   input  logic              reset_b,
   input  logic              enable,
   input  logic              d_in,
   input  logic              frame_sync,
   output logic [N_CH*W-1:0] ch_data,
   output logic [N_CH-1:0]   ch_valid,
   output logic              frame_done,
   output logic              locked,
   output logic              sync_err
);

   localparam int BW = (W > 2) ? $clog2(W) : 1;
   localparam int SW = (N_CH > 2) ? $clog2(N_CH) : 1;
   localparam logic [BW-1:0] BIT_LAST  = BW'(W - 1);
   localparam logic [SW-1:0] SLOT_LAST = SW'(N_CH - 1);

   typedef enum logic {HUNT, RUN} state_t;

   state_t        state;
   logic [BW-1:0] bit_cnt;
   logic [SW-1:0] slot_cnt;
   logic [W-2:0]  shreg;
   logic          miss;
   logic [W-1:0]  word;
   logic          boundary;

   // Word as it would stand including the bit on the line this cycle.
   always_comb begin
      word     = {shreg, d_in};
      boundary = (bit_cnt == '0) && (slot_cnt == '0);
   end

   // Framing FSM, deserialiser and registered outputs; pulses last one clock.
   always_ff @(posedge clock or negedge reset_b) begin
      if (!reset_b) begin
         state      <= HUNT;
         bit_cnt    <= '0;
         slot_cnt   <= '0;
         shreg      <= '0;
         miss       <= 1'b0;
         ch_data    <= '0;
         ch_valid   <= '0;
         frame_done <= 1'b0;
         locked     <= 1'b0;
         sync_err   <= 1'b0;
      end else begin
         ch_valid   <= '0;
         frame_done <= 1'b0;
         sync_err   <= 1'b0;
         if (enable) begin
            case (state)
               HUNT: begin
                  if (frame_sync) begin
                     state    <= RUN;
                     locked   <= 1'b1;
                     shreg    <= word[W-2:0];
                     bit_cnt  <= BW'(1);
                     slot_cnt <= '0;
                     miss     <= 1'b0;
                  end
               end
               RUN: begin
                  if (frame_sync && !boundary) begin
                     // Misplaced sync: drop the partial word and realign on this bit.
                     sync_err <= 1'b1;
                     shreg    <= word[W-2:0];
                     bit_cnt  <= BW'(1);
                     slot_cnt <= '0;
                     miss     <= 1'b0;
                  end else if (boundary && !frame_sync && miss) begin
                     // Two boundaries in a row without sync: lock is lost.
                     state    <= HUNT;
                     locked   <= 1'b0;
                     bit_cnt  <= '0;
                     slot_cnt <= '0;
                     miss     <= 1'b0;
                  end else begin
                     if (boundary) begin
                        miss <= !frame_sync;
                     end
                     shreg <= word[W-2:0];
                     if (bit_cnt == BIT_LAST) begin
                        for (int k = 0; k < N_CH; k++) begin
                           if (slot_cnt == SW'(k)) begin
                              ch_data[k*W +: W] <= word;
                              ch_valid[k]       <= 1'b1;
                           end
                        end
                        frame_done <= (slot_cnt == SLOT_LAST);
                        bit_cnt    <= '0;
                        slot_cnt   <= (slot_cnt == SLOT_LAST) ? '0 : slot_cnt + 1'b1;
                     end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                     end
                  end
               end
               default: state <= HUNT;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_tdm_demux_rx.sv
// tb/tb_tdm_demux_rx.sv - directed self-checking bench for tdm_demux_rx
module tb_tdm_demux_rx;

   logic        clock = 1'b0;
   logic        reset_b;
   logic        enable, d_in, frame_sync;
   logic [31:0] ch_data;
   logic [3:0]  ch_valid;
   logic        frame_done, locked, sync_err;

   logic        en2, d2, fs2;
   logic [7:0]  ch_data2;
   logic [1:0]  ch_valid2;
   logic        frame_done2, locked2, sync_err2;

   int errors = 0;
   int checks = 0;

   always #5 clock = ~clock;

   tdm_demux_rx #(.N_CH(4), .W(8)) dut (
      .clock(clock), .reset_b(reset_b), .enable(enable), .d_in(d_in), .frame_sync(frame_sync),
      .ch_data(ch_data), .ch_valid(ch_valid), .frame_done(frame_done), .locked(locked), .sync_err(sync_err)
   );

   tdm_demux_rx #(.N_CH(2), .W(4)) dut2 (
      .clock(clock), .reset_b(reset_b), .enable(en2), .d_in(d2), .frame_sync(fs2),
      .ch_data(ch_data2), .ch_valid(ch_valid2), .frame_done(frame_done2), .locked(locked2), .sync_err(sync_err2)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic bit1(input logic en, input logic d, input logic fs);
      enable = en; d_in = d; frame_sync = fs;
      @(posedge clock); #1;
   endtask

   task automatic send_word(input logic [7:0] w, input logic fs, input logic [3:0] vexp,
                            input logic serr_exp, input logic gap);
      for (int i = 7; i >= 0; i--) begin
         bit1(1'b1, w[i], fs && (i == 7));
         if (i == 7) chk("sync_err", 32'(sync_err), 32'(serr_exp));
         chk("ch_valid", 32'(ch_valid), (i == 0) ? 32'(vexp) : 32'h0);
         if (i == 0) chk("frame_done", 32'(frame_done), 32'(vexp[3]));
         if (gap) begin
            bit1(1'b0, ~w[i], 1'b1);
            chk("gap_valid", 32'(ch_valid), 32'h0);
            chk("gap_serr", 32'(sync_err), 32'h0);
         end
      end
      enable = 1'b0;
   endtask

   task automatic send_nib(input logic [3:0] n, input logic fs, input logic [1:0] vexp);
      for (int i = 3; i >= 0; i--) begin
         en2 = 1'b1; d2 = n[i]; fs2 = fs && (i == 3);
         @(posedge clock); #1;
         chk("ch_valid2", 32'(ch_valid2), (i == 0) ? 32'(vexp) : 32'h0);
         if (i == 0) chk("frame_done2", 32'(frame_done2), 32'(vexp[1]));
      end
      en2 = 1'b0;
   endtask

   initial begin
      reset_b = 1'b0; enable = 1'b0; d_in = 1'b0; frame_sync = 1'b0;
      en2 = 1'b0; d2 = 1'b0; fs2 = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      chk("rst_data", ch_data, 32'h0);
      chk("rst_valid", 32'(ch_valid), 32'h0);
      chk("rst_locked", 32'(locked), 32'h0);
      chk("rst_fdone", 32'(frame_done), 32'h0);
      reset_b = 1'b1;

      // Test 1: synced frame A5,3C,FF,00
      bit1(1'b0, 1'b1, 1'b0);
      send_word(8'hA5, 1'b1, 4'h1, 1'b0, 1'b0);
      chk("t1_locked", 32'(locked), 32'h1);
      send_word(8'h3C, 1'b0, 4'h2, 1'b0, 1'b0);
      send_word(8'hFF, 1'b0, 4'h4, 1'b0, 1'b0);
      send_word(8'h00, 1'b0, 4'h8, 1'b0, 1'b0);
      chk("t1_data", ch_data, 32'h00FF3CA5);

      // Test 2: synced frame, one flywheel frame, then lock loss
      send_word(8'hA5, 1'b1, 4'h1, 1'b0, 1'b0);
      send_word(8'h3C, 1'b0, 4'h2, 1'b0, 1'b0);
      send_word(8'hFF, 1'b0, 4'h4, 1'b0, 1'b0);
      send_word(8'h00, 1'b0, 4'h8, 1'b0, 1'b0);
      send_word(8'h81, 1'b0, 4'h1, 1'b0, 1'b0);
      send_word(8'h42, 1'b0, 4'h2, 1'b0, 1'b0);
      send_word(8'h24, 1'b0, 4'h4, 1'b0, 1'b0);
      send_word(8'h18, 1'b0, 4'h8, 1'b0, 1'b0);
      chk("t2_data_fly", ch_data, 32'h18244281);
      chk("t2_locked_fly", 32'(locked), 32'h1);
      send_word(8'h55, 1'b0, 4'h0, 1'b0, 1'b0);
      chk("t2_unlocked", 32'(locked), 32'h0);
      send_word(8'h66, 1'b0, 4'h0, 1'b0, 1'b0);
      send_word(8'h77, 1'b0, 4'h0, 1'b0, 1'b0);
      send_word(8'h88, 1'b0, 4'h0, 1'b0, 1'b0);
      chk("t2_data_hold", ch_data, 32'h18244281);

      // Test 3: sync at frame bit 13, realigned frame 11,22,33,44
      send_word(8'hA5, 1'b1, 4'h1, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         bit1(1'b1, 1'b1, 1'b0);
         chk("t3_partial_valid", 32'(ch_valid), 32'h0);
      end
      send_word(8'h11, 1'b1, 4'h1, 1'b1, 1'b0);
      chk("t3_slot1_held", 32'(ch_data[15:8]), 32'h42);
      chk("t3_locked", 32'(locked), 32'h1);
      send_word(8'h22, 1'b0, 4'h2, 1'b0, 1'b0);
      send_word(8'h33, 1'b0, 4'h4, 1'b0, 1'b0);
      send_word(8'h44, 1'b0, 4'h8, 1'b0, 1'b0);
      chk("t3_data", ch_data, 32'h44332211);

      // Test 4: enable toggling every cycle, idle cycles carry ignored frame_sync
      send_word(8'hA5, 1'b1, 4'h1, 1'b0, 1'b1);
      send_word(8'h3C, 1'b0, 4'h2, 1'b0, 1'b1);
      send_word(8'hFF, 1'b0, 4'h4, 1'b0, 1'b1);
      send_word(8'h00, 1'b0, 4'h8, 1'b0, 1'b1);
      chk("t4_data", ch_data, 32'h00FF3CA5);

      // Test 5: async reset at frame bit 20
      send_word(8'h81, 1'b1, 4'h1, 1'b0, 1'b0);
      send_word(8'h42, 1'b0, 4'h2, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) bit1(1'b1, 1'b1, 1'b0);
      reset_b = 1'b0;
      #1;
      chk("t5_async_data", ch_data, 32'h0);
      chk("t5_async_locked", 32'(locked), 32'h0);
      chk("t5_async_valid", 32'(ch_valid), 32'h0);
      @(posedge clock); #1;
      reset_b = 1'b1;
      send_word(8'hFF, 1'b0, 4'h0, 1'b0, 1'b0);
      chk("t5_hunt_locked", 32'(locked), 32'h0);
      chk("t5_hunt_data", ch_data, 32'h0);
      send_word(8'h81, 1'b1, 4'h1, 1'b0, 1'b0);
      send_word(8'h42, 1'b0, 4'h2, 1'b0, 1'b0);
      send_word(8'h24, 1'b0, 4'h4, 1'b0, 1'b0);
      send_word(8'h18, 1'b0, 4'h8, 1'b0, 1'b0);
      chk("t5_data", ch_data, 32'h18244281);

      // Test 6: N_CH=2, W=4 instance
      chk("t6_locked_pre", 32'(locked2), 32'h0);
      send_nib(4'h9, 1'b1, 2'b01);
      chk("t6_locked", 32'(locked2), 32'h1);
      send_nib(4'h6, 1'b0, 2'b10);
      chk("t6_data", 32'(ch_data2), 32'h69);
      send_nib(4'h3, 1'b1, 2'b01);
      chk("t6_wrap_data", 32'(ch_data2), 32'h63);
      send_nib(4'hC, 1'b0, 2'b10);
      chk("t6_data2", 32'(ch_data2), 32'hC3);
      chk("t6_serr", 32'(sync_err2), 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
